// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if
//   Bundles the decode-side inputs and the EX-side outputs of the ID/EX
//   pipeline register.
//   master : decode side. Drives the register specifiers, operands, control
//            and Flush. Observes Stall and the registered EX slot.
//   slave  : the ID/EX stage itself.
//   Parameters: DATA_W (operand width), ALUOP_W (ALU op width),
//               CNT_W (bubble counter width).
interface id_ex_stage_if #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
);
  // decode side
  logic [4:0]         IF_ID_Rs;
  logic [4:0]         IF_ID_Rt;
  logic [4:0]         IF_ID_Rd;
  logic               IF_ID_Valid;
  logic [DATA_W-1:0]  ReadData1;
  logic [DATA_W-1:0]  ReadData2;
  logic [DATA_W-1:0]  SignImm;
  logic               ID_RegWrite;
  logic               ID_MemtoReg;
  logic               ID_MemRead;
  logic               ID_MemWrite;
  logic               ID_ALUSrc;
  logic               ID_RegDst;
  logic [ALUOP_W-1:0] ID_ALUOp;
  logic               Flush;

  // stage outputs
  logic               Stall;
  logic               ID_EX_Valid;
  logic [4:0]         ID_EX_Rs;
  logic [4:0]         ID_EX_Rt;
  logic [4:0]         ID_EX_Rd;
  logic [DATA_W-1:0]  ID_EX_A;
  logic [DATA_W-1:0]  ID_EX_B;
  logic [DATA_W-1:0]  ID_EX_Imm;
  logic               ID_EX_RegWrite;
  logic               ID_EX_MemtoReg;
  logic               ID_EX_MemRead;
  logic               ID_EX_MemWrite;
  logic               ID_EX_ALUSrc;
  logic               ID_EX_RegDst;
  logic [ALUOP_W-1:0] ID_EX_ALUOp;
  logic [CNT_W-1:0]   BubbleCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Valid,
    output ReadData1, ReadData2, SignImm,
    output ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
    output ID_ALUOp, Flush,
    input  Stall, ID_EX_Valid, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    input  ID_EX_A, ID_EX_B, ID_EX_Imm,
    input  ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite,
    input  ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp, BubbleCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, IF_ID_Valid,
    input  ReadData1, ReadData2, SignImm,
    input  ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst,
    input  ID_ALUOp, Flush,
    output Stall, ID_EX_Valid, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd,
    output ID_EX_A, ID_EX_B, ID_EX_Imm,
    output ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite,
    output ID_EX_ALUSrc, ID_EX_RegDst, ID_EX_ALUOp, BubbleCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode-to-execute pipeline register of the 5-stage MIPS core. Latches
//   register-file data, immediate, specifiers and decode control every cycle,
//   detects load-use hazards (Stall back to PC/IF-ID plus a bubble into EX),
//   honours branch Flush, and keeps a saturating count of inserted bubbles.
//   Ports:
//     clk : pipeline clock, all state changes on posedge
//     rst : synchronous active-high reset
//     bus : id_ex_stage_if slave modport (decode inputs, EX outputs, Stall,
//           BubbleCount)
module id_ex_stage #(
  parameter int DATA_W  = 32,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic               valid;
    logic [4:0]         rs;
    logic [4:0]         rt;
    logic [4:0]         rd;
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [DATA_W-1:0]  imm;
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic               reg_dst;
    logic [ALUOP_W-1:0] alu_op;
  } ex_slot_t;

  ex_slot_t         ex_q, ex_d;
  logic [CNT_W-1:0] bubble_count_q, bubble_count_d;
  logic             load_use;
  logic             stall;
  logic             bubble;

  // Load-use detection. The Rt compare is deliberately unconditional: an
  // I-type in decode may stall needlessly, which is safe. A load into $0
  // never stalls since $0 is never really written.
  always_comb begin
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rt != 5'd0) & bus.IF_ID_Valid &
               ((ex_q.rt == bus.IF_ID_Rs) | (ex_q.rt == bus.IF_ID_Rt));
    stall    = load_use & ~bus.Flush;
    bubble   = bus.Flush | stall;
  end

  // Next EX slot: a bubble is an all-zero slot; otherwise capture decode.
  // Data is captured even for an invalid decode slot, control is not.
  always_comb begin
    ex_d           = '0;
    bubble_count_d = bubble_count_q;
    if (bubble) begin
      if (bubble_count_q != {CNT_W{1'b1}}) begin
        bubble_count_d = bubble_count_q + CNT_W'(1);
      end
    end else begin
      ex_d.valid = bus.IF_ID_Valid;
      ex_d.rs    = bus.IF_ID_Rs;
      ex_d.rt    = bus.IF_ID_Rt;
      ex_d.rd    = bus.IF_ID_Rd;
      ex_d.a     = bus.ReadData1;
      ex_d.b     = bus.ReadData2;
      ex_d.imm   = bus.SignImm;
      if (bus.IF_ID_Valid) begin
        ex_d.reg_write  = bus.ID_RegWrite;
        ex_d.mem_to_reg = bus.ID_MemtoReg;
        ex_d.mem_read   = bus.ID_MemRead;
        ex_d.mem_write  = bus.ID_MemWrite;
        ex_d.alu_src    = bus.ID_ALUSrc;
        ex_d.reg_dst    = bus.ID_RegDst;
        ex_d.alu_op     = bus.ID_ALUOp;
      end
    end
  end

  // Pipeline register and bubble counter; reset overrides any flush/stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.Stall          = stall;
  assign bus.ID_EX_Valid    = ex_q.valid;
  assign bus.ID_EX_Rs       = ex_q.rs;
  assign bus.ID_EX_Rt       = ex_q.rt;
  assign bus.ID_EX_Rd       = ex_q.rd;
  assign bus.ID_EX_A        = ex_q.a;
  assign bus.ID_EX_B        = ex_q.b;
  assign bus.ID_EX_Imm      = ex_q.imm;
  assign bus.ID_EX_RegWrite = ex_q.reg_write;
  assign bus.ID_EX_MemtoReg = ex_q.mem_to_reg;
  assign bus.ID_EX_MemRead  = ex_q.mem_read;
  assign bus.ID_EX_MemWrite = ex_q.mem_write;
  assign bus.ID_EX_ALUSrc   = ex_q.alu_src;
  assign bus.ID_EX_RegDst   = ex_q.reg_dst;
  assign bus.ID_EX_ALUOp    = ex_q.alu_op;
  assign bus.BubbleCount    = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage with a 4-bit bubble counter so that
//   saturation is reachable. Expected values come from a behavioural model of
//   the EX slot: "the instruction that was in decode last cycle, or nothing".
module tb_id_ex_stage;

  localparam int DATA_W  = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        as;
    logic        rdst;
    logic [3:0]  op;
    logic        flush;
  } in_t;

  logic clk;
  logic rst;

  id_ex_stage_if #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage #(.DATA_W(DATA_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;

  // model state: what EX should hold, and how many bubbles were counted
  in_t  cur;
  in_t  m_slot;
  int   exp_count;

  function automatic logic [121:0] slot_vec(input in_t s);
    return {s.valid, s.rs, s.rt, s.rd, s.rd1, s.rd2, s.imm,
            s.rw, s.m2r, s.mr, s.mw, s.as, s.rdst, s.op};
  endfunction

  function automatic logic [121:0] dut_vec();
    return {bus.ID_EX_Valid, bus.ID_EX_Rs, bus.ID_EX_Rt, bus.ID_EX_Rd,
            bus.ID_EX_A, bus.ID_EX_B, bus.ID_EX_Imm,
            bus.ID_EX_RegWrite, bus.ID_EX_MemtoReg, bus.ID_EX_MemRead,
            bus.ID_EX_MemWrite, bus.ID_EX_ALUSrc, bus.ID_EX_RegDst, bus.ID_EX_ALUOp};
  endfunction

  // a real load in EX whose target (not $0) is read by a real decode instr
  function automatic logic exp_stall();
    logic dep;
    dep = m_slot.valid && m_slot.mr && (m_slot.rt != 5'd0) && cur.valid &&
          ((m_slot.rt == cur.rs) || (m_slot.rt == cur.rt));
    return dep && !cur.flush;
  endfunction

  function automatic in_t rand_in(input int reg_max);
    in_t s;
    s.valid = ($urandom_range(3) != 0);
    s.rs    = 5'($urandom_range(reg_max));
    s.rt    = 5'($urandom_range(reg_max));
    s.rd    = 5'($urandom_range(reg_max));
    s.rd1   = $urandom();
    s.rd2   = $urandom();
    s.imm   = $urandom();
    s.rw    = 1'($urandom_range(1));
    s.m2r   = 1'($urandom_range(1));
    s.mr    = 1'($urandom_range(1));
    s.mw    = 1'($urandom_range(1));
    s.as    = 1'($urandom_range(1));
    s.rdst  = 1'($urandom_range(1));
    s.op    = 4'($urandom_range(15));
    s.flush = ($urandom_range(7) == 0);
    return s;
  endfunction

  function automatic in_t instr(input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic is_load);
    in_t s;
    s       = '0;
    s.valid = 1'b1;
    s.rs    = rs;
    s.rt    = rt;
    s.rd    = rd;
    s.rd1   = 32'h1000 + 32'(rs);
    s.rd2   = 32'h2000 + 32'(rt);
    s.imm   = 32'h0000_0010;
    s.rw    = 1'b1;
    s.m2r   = is_load;
    s.mr    = is_load;
    s.as    = is_load;
    s.rdst  = ~is_load;
    s.op    = is_load ? 4'd0 : 4'd2;
    return s;
  endfunction

  // drive decode inputs away from the active edge and let them settle
  task automatic apply_stimulus(input in_t s, input logic r);
    @(negedge clk);
    rst             = r;
    cur             = s;
    bus.IF_ID_Rs    = s.rs;
    bus.IF_ID_Rt    = s.rt;
    bus.IF_ID_Rd    = s.rd;
    bus.IF_ID_Valid = s.valid;
    bus.ReadData1   = s.rd1;
    bus.ReadData2   = s.rd2;
    bus.SignImm     = s.imm;
    bus.ID_RegWrite = s.rw;
    bus.ID_MemtoReg = s.m2r;
    bus.ID_MemRead  = s.mr;
    bus.ID_MemWrite = s.mw;
    bus.ID_ALUSrc   = s.as;
    bus.ID_RegDst   = s.rdst;
    bus.ID_ALUOp    = s.op;
    bus.Flush       = s.flush;
    #1;
  endtask

  // advance one clock and the model alongside it
  task automatic clock_edge();
    logic st;
    st = exp_stall();
    @(posedge clk);
    if (rst) begin
      m_slot    = '0;
      exp_count = 0;
    end else if (cur.flush || st) begin
      m_slot = '0;
      if (exp_count < CNT_MAX) exp_count++;
    end else begin
      m_slot       = cur;
      m_slot.flush = 1'b0;
      if (!cur.valid) begin
        m_slot.rw = 0; m_slot.m2r = 0; m_slot.mr = 0;
        m_slot.mw = 0; m_slot.as = 0;  m_slot.rdst = 0; m_slot.op = '0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(rand_in(31), 1'b1);
      clock_edge();
      n_checks++;
      if (dut_vec() !== slot_vec(m_slot) || dut_vec() !== 122'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_slot: got %h expected %h", dut_vec(), slot_vec(m_slot));
      end
      n_checks++;
      if (bus.BubbleCount !== 4'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_count: got %0d expected 0", bus.BubbleCount);
      end
    end
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_stall: got %b expected 0", bus.Stall);
    end
  endtask

  task automatic test_pass_through();
    in_t s;
    s      = instr(5'd2, 5'd3, 5'd4, 1'b0);
    s.rd1  = 32'd2;
    s.rd2  = 32'd3;
    s.imm  = 32'hFFFF_FFF0;
    s.m2r  = 0; s.as = 0; s.rdst = 0;
    apply_stimulus(s, 1'b0);
    n_checks++;
    if (bus.Stall !== exp_stall()) begin
      n_fail++;
      $display("[TB] FAIL pass_stall: got %b expected %b", bus.Stall, exp_stall());
    end
    clock_edge();
    n_checks++;
    if (dut_vec() !== slot_vec(m_slot)) begin
      n_fail++;
      $display("[TB] FAIL pass_slot: got %h expected %h", dut_vec(), slot_vec(m_slot));
    end
    n_checks++;
    if (bus.ID_EX_A !== 32'd2 || bus.ID_EX_B !== 32'd3 || bus.ID_EX_Imm !== 32'hFFFF_FFF0 ||
        bus.ID_EX_ALUOp !== 4'd2 || bus.ID_EX_RegWrite !== 1'b1 || bus.ID_EX_Valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pass_fields: got A=%h B=%h Imm=%h op=%0d rw=%b v=%b expected 2 3 fffffff0 2 1 1",
               bus.ID_EX_A, bus.ID_EX_B, bus.ID_EX_Imm, bus.ID_EX_ALUOp,
               bus.ID_EX_RegWrite, bus.ID_EX_Valid);
    end
  endtask

  task automatic test_load_use();
    int start;
    apply_stimulus(instr(5'd1, 5'd5, 5'd0, 1'b1), 1'b0);
    clock_edge();
    start = exp_count;
    // dependent add held in decode until the stall clears
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(instr(5'd5, 5'd6, 5'd7, 1'b0), 1'b0);
      n_checks++;
      if (bus.Stall !== exp_stall() || bus.Stall !== (i == 0)) begin
        n_fail++;
        $display("[TB] FAIL load_use_stall%0d: got %b expected %b", i, bus.Stall, exp_stall());
      end
      clock_edge();
      n_checks++;
      if (dut_vec() !== slot_vec(m_slot)) begin
        n_fail++;
        $display("[TB] FAIL load_use_slot%0d: got %h expected %h", i, dut_vec(), slot_vec(m_slot));
      end
    end
    n_checks++;
    if (int'(bus.BubbleCount) !== exp_count || exp_count != start + 1) begin
      n_fail++;
      $display("[TB] FAIL load_use_count: got %0d expected %0d", bus.BubbleCount, start + 1);
    end
  endtask

  task automatic test_back_to_back();
    in_t seq [4];
    seq[0] = instr(5'd1, 5'd9, 5'd0, 1'b1);
    seq[1] = instr(5'd9, 5'd10, 5'd0, 1'b1);
    seq[2] = instr(5'd10, 5'd11, 5'd12, 1'b0);
    seq[3] = instr(5'd3, 5'd4, 5'd13, 1'b0);
    for (int i = 0; i < 4; i++) begin
      do begin
        apply_stimulus(seq[i], 1'b0);
        n_checks++;
        if (bus.Stall !== exp_stall()) begin
          n_fail++;
          $display("[TB] FAIL b2b_stall%0d: got %b expected %b", i, bus.Stall, exp_stall());
        end
        clock_edge();
        n_checks++;
        if (dut_vec() !== slot_vec(m_slot) || int'(bus.BubbleCount) !== exp_count) begin
          n_fail++;
          $display("[TB] FAIL b2b_slot%0d: got %h/%0d expected %h/%0d", i, dut_vec(),
                   bus.BubbleCount, slot_vec(m_slot), exp_count);
        end
      end while (m_slot.valid == 1'b0);
    end
  endtask

  task automatic test_zero_exempt();
    int start;
    apply_stimulus(instr(5'd1, 5'd0, 5'd0, 1'b1), 1'b0);
    clock_edge();
    start = exp_count;
    apply_stimulus(instr(5'd0, 5'd0, 5'd8, 1'b0), 1'b0);
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_stall: got %b expected 0", bus.Stall);
    end
    clock_edge();
    n_checks++;
    if (dut_vec() !== slot_vec(m_slot) || int'(bus.BubbleCount) !== start) begin
      n_fail++;
      $display("[TB] FAIL zero_slot: got %h/%0d expected %h/%0d", dut_vec(),
               bus.BubbleCount, slot_vec(m_slot), start);
    end
  endtask

  task automatic test_flush_priority();
    in_t s;
    int  start;
    apply_stimulus(instr(5'd1, 5'd5, 5'd0, 1'b1), 1'b0);
    clock_edge();
    start   = exp_count;
    s       = instr(5'd5, 5'd6, 5'd7, 1'b0);
    s.flush = 1'b1;
    apply_stimulus(s, 1'b0);
    n_checks++;
    if (bus.Stall !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL flush_stall: got %b expected 0", bus.Stall);
    end
    clock_edge();
    n_checks++;
    if (dut_vec() !== 122'd0 || int'(bus.BubbleCount) !== start + 1 || exp_count != start + 1) begin
      n_fail++;
      $display("[TB] FAIL flush_bubble: got %h/%0d expected 0/%0d", dut_vec(),
               bus.BubbleCount, start + 1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(rand_in(3), ($urandom_range(31) == 0));
      n_checks++;
      if (bus.Stall !== exp_stall()) begin
        n_fail++;
        $display("[TB] FAIL rand_stall%0d: got %b expected %b", i, bus.Stall, exp_stall());
      end
      clock_edge();
      n_checks++;
      if (dut_vec() !== slot_vec(m_slot) || int'(bus.BubbleCount) !== exp_count) begin
        n_fail++;
        $display("[TB] FAIL rand_slot%0d: got %h/%0d expected %h/%0d", i, dut_vec(),
                 bus.BubbleCount, slot_vec(m_slot), exp_count);
      end
    end
  endtask

  task automatic test_saturation();
    in_t s;
    for (int i = 0; i < 20; i++) begin
      s       = rand_in(31);
      s.flush = 1'b1;
      apply_stimulus(s, 1'b0);
      clock_edge();
      n_checks++;
      if (int'(bus.BubbleCount) !== exp_count) begin
        n_fail++;
        $display("[TB] FAIL sat_count%0d: got %0d expected %0d", i, bus.BubbleCount, exp_count);
      end
    end
    n_checks++;
    if (bus.BubbleCount !== 4'd15) begin
      n_fail++;
      $display("[TB] FAIL sat_final: got %0d expected 15", bus.BubbleCount);
    end
    // reset together with a flush: reset wins, nothing counted
    apply_stimulus(s, 1'b1);
    clock_edge();
    n_checks++;
    if (bus.BubbleCount !== 4'd0 || dut_vec() !== 122'd0) begin
      n_fail++;
      $display("[TB] FAIL sat_reset: got %0d/%h expected 0/0", bus.BubbleCount, dut_vec());
    end
  endtask

  initial begin
    m_slot    = '0;
    exp_count = 0;
    cur       = '0;
    rst       = 1'b1;
    bus.IF_ID_Rs = '0; bus.IF_ID_Rt = '0; bus.IF_ID_Rd = '0; bus.IF_ID_Valid = 1'b0;
    bus.ReadData1 = '0; bus.ReadData2 = '0; bus.SignImm = '0;
    bus.ID_RegWrite = 1'b0; bus.ID_MemtoReg = 1'b0; bus.ID_MemRead = 1'b0;
    bus.ID_MemWrite = 1'b0; bus.ID_ALUSrc = 1'b0; bus.ID_RegDst = 1'b0;
    bus.ID_ALUOp = '0; bus.Flush = 1'b0;

    test_reset();
    test_pass_through();
    test_load_use();
    test_back_to_back();
    test_zero_exempt();
    test_flush_priority();
    test_random();
    test_saturation();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage MIPS core, directly downstream of the register file.
- Latches the register-file read data, sign-extended immediate, register specifiers and decode control each cycle.
- Contains the load-use hazard detector: drives Stall back to the PC and IF/ID registers, and inserts a bubble into EX.
- Honours branch Flush and counts inserted bubbles for debug.

Parameters:
DATA_W, 32, datapath width (ReadData1/2, SignImm)
ALUOP_W, 4, ALU operation code width
CNT_W, 16, bubble counter width

Ports:
clk  input  1  pipeline clock; all state updates on posedge
rst  input  1  synchronous active-high reset
IF_ID_Rs  input  5  source register 1 of the instruction in decode
IF_ID_Rt  input  5  source register 2 of the instruction in decode
IF_ID_Rd  input  5  destination field (R-type) of the instruction in decode
IF_ID_Valid  input  1  decode slot holds a real instruction
ReadData1  input  DATA_W  register-file read port 1; stable from negedge until next posedge
ReadData2  input  DATA_W  register-file read port 2
SignImm  input  DATA_W  sign-extended immediate
ID_RegWrite, ID_MemtoReg, ID_MemRead, ID_MemWrite, ID_ALUSrc, ID_RegDst  input  1 each  decode control
ID_ALUOp  input  ALUOP_W  decode ALU op
Flush  input  1  kill the instruction in decode (taken branch/jump)
Stall  output  1  combinational; hold PC and IF/ID when 1
ID_EX_Valid  output  1  EX slot holds a real instruction
ID_EX_Rs, ID_EX_Rt, ID_EX_Rd  output  5 each  registered specifiers
ID_EX_A, ID_EX_B, ID_EX_Imm  output  DATA_W each  registered operands
ID_EX_RegWrite, ID_EX_MemtoReg, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_ALUSrc, ID_EX_RegDst  output  1 each  registered control
ID_EX_ALUOp  output  ALUOP_W  registered ALU op
BubbleCount  output  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (rst=1 at posedge):
  - All ID_EX_* outputs clear to 0, including ID_EX_Valid.
  - BubbleCount clears to 0.
  - Stall evaluates to 0 after reset because ID_EX_Valid=0.
- Hazard detection (combinational):
  - load_use = ID_EX_Valid & ID_EX_MemRead & (ID_EX_Rt != 0) & IF_ID_Valid & ((ID_EX_Rt == IF_ID_Rs) | (ID_EX_Rt == IF_ID_Rt)).
  - The Rt compare is unconditional. This is conservative by design: an I-type instruction in decode may stall unnecessarily.
  - Stall = load_use & ~Flush.
- Register update at each posedge, when rst=0, in priority order:
  1. Flush=1 or Stall=1: insert a bubble. ID_EX_Valid=0, all control outputs 0, and specifier and data outputs cleared to 0. BubbleCount increments.
  2. Otherwise: capture all inputs. ID_EX_Valid=IF_ID_Valid. If IF_ID_Valid=0, control outputs are forced to 0 and data is still captured.
- Latency: exactly one cycle from decode inputs to ID_EX_* outputs.
- Stall length:
  - A load-use stall lasts exactly one cycle, because the bubble sets ID_EX_MemRead=0.
  - Back-to-back loads with a dependency each stall one cycle.
- Simultaneous events:
  - Flush with load_use: Flush wins, Stall=0, one bubble, counted once.
  - rst together with Flush or Stall: reset wins, and the counter does not increment.
- BubbleCount:
  - Increments by 1 per bubble cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Register $0:
  - A load whose destination is $0 never stalls.
  - No write-back forwarding is done here. The register file's write-posedge / read-negedge ordering already returns the WB value in the same cycle.
- ReadData1/2 are sampled only at posedge; any negedge updates from the register file are picked up at the next posedge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> all ID_EX_* = 0, BubbleCount=0, Stall=0.
- Pass-through: IF_ID_Rs=2, Rt=3, Rd=4, ReadData1=2, ReadData2=3, SignImm=0xFFFFFFF0, ID_RegWrite=1, ID_ALUOp=2 -> next cycle ID_EX_A=2, ID_EX_B=3, ID_EX_Imm=0xFFFFFFF0, ID_EX_RegWrite=1, ID_EX_ALUOp=2, Valid=1.
- Load-use: lw with Rt=5 captured into EX (ID_EX_MemRead=1), then decode add with Rs=5 -> Stall=1 for exactly one cycle, then EX holds a bubble (Valid=0, RegWrite=0) and BubbleCount=1. On the next cycle the add is captured with Stall=0.
- $0 exemption: lw with Rt=0 followed by decode Rs=0 -> Stall=0, no bubble.
- Flush priority: same load-use setup plus Flush=1 -> Stall=0, one bubble, BubbleCount increments by 1 only.
- Saturation: CNT_W=4, hold Flush=1 for 20 cycles -> BubbleCount stops at 15. Then rst=1 -> BubbleCount=0.
